bcd_to_bin_4digit: RTL and testbench
====================================

Name: bcd_to_bin_4digit

Overview:
- Sequential 4-digit BCD-to-binary converter: the inverse of the team's binary-to-BCD digit path.
- Converts operator-entered or stored BCD values (e.g. a best-time threshold set on the switches, 0000-9999 ms) back into a binary count.
- The binary count is then compared against the reaction-timer millisecond counter.
- Uses iterative reverse double-dabble: one shift/correct step per clock, start/done handshake, digit validation and 13-bit range flag.

Parameters:
- MAX_VAL, 8191, largest value representable by the downstream 13-bit timer; results above it assert ovf.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- thousands  input  4  BCD digit, most significant
- hundreds  input  4  BCD digit
- tens  input  4  BCD digit
- ones  input  4  BCD digit, least significant
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: result/flags valid and updated
- bin  output  14  binary result, 0..9999
- ovf  output  1  result > MAX_VAL (valid with done, held after)
- err  output  1  at least one input digit > 9 (valid with done, held after)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, bin=0, ovf=0, err=0; shift register and counter cleared. Asserting rst mid-conversion aborts it; no done is produced.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0, every digit <= 9:
  - Load 30-bit work register {bcd[15:0]=thousands,hundreds,tens,ones ; acc[13:0]=0}.
  - cnt=0, busy=1, go to SHIFT.
- IDLE, start=1 at E0, any digit in 10..15:
  - No conversion. At E0: done=1, err=1, bin=0, ovf=0, busy stays 0, remain IDLE.
- SHIFT, each edge performs one iteration:
  - Logical right-shift of the whole 30-bit register by 1; the bcd LSB enters acc MSB.
  - Then, for each of the 4 nibbles of the shifted bcd field independently: if nibble >= 8, subtract 3.
  - Register the result; cnt increments.
- Exactly 14 iterations (edges E1..E14). At E14:
  - bin = acc; ovf = (acc > MAX_VAL); err=0.
  - done=1, busy=0, state=IDLE.
- Latency: valid start to done = 14 cycles. Invalid-digit start to done = 1 cycle.
- done is high for exactly one cycle after the setting edge, then returns to 0.
- bin/ovf/err hold their values until the next done.
- start while busy=1 is ignored (not queued). Digit inputs are sampled only at the accepting edge; changes during SHIFT have no effect.
- Back-to-back: start held high, or reasserted in the cycle done is high, is accepted at E15. Throughput is 15 cycles per conversion.
- Arithmetic: the 14-bit result covers 9999 (0x270F). Nibble correction never underflows, because a nibble >= 8 after a right shift always came from a valid digit. cnt is 4 bits and never exceeds 14.

Test Plan:
- Reset, then start with 0,0,0,0 -> busy high for E1..E14, done pulse after E14, bin=0, ovf=0, err=0; busy=0 after E14.
- Start with 1,2,3,4 -> bin=1234 (0x04D2), ovf=0, done exactly 14 cycles after accept; follow with 8,1,9,1 -> bin=8191 (0x1FFF), ovf=0.
- Start with 9,9,9,9 -> bin=9999 (0x270F), ovf=1; then 8,1,9,2 -> bin=8192, ovf=1.
- Start with 0,0,A,5 (tens=0xA) -> done and err=1 one cycle after start, bin=0, busy never asserted; a following valid 0,0,4,2 start clears err, bin=42.
- Start 5,0,0,0 then pulse start with 0,0,0,1 at E5 -> second request ignored, bin=5000; hold start high through done -> second conversion accepted at E15, done at E29.
- Start 7,7,7,7, assert rst asynchronously mid-cycle between E6 and E7 -> all outputs 0 immediately, no done ever pulses; after release, start 0,0,0,9 -> bin=9.

Source files
------------

// File: rtl/bcd_to_bin_4digit.sv
// Sequential 4-digit BCD to 14-bit binary converter.
// Reverse double-dabble: one right-shift plus per-nibble correction per clock,
// with a start/done handshake, invalid-digit detection and a range flag for
// the downstream 13-bit millisecond timer.
module bcd_to_bin_4digit #(
  parameter int MAX_VAL = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        busy,
  output logic        done,
  output logic [13:0] bin,
  output logic        ovf,
  output logic        err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [13:0] MAX_BIN = 14'(MAX_VAL);
  localparam logic [3:0]  LAST_ITER = 4'd13;

  state_t      state;
  // work[29:14] = BCD digits being drained, work[13:0] = binary accumulator
  logic [29:0] work;
  logic [29:0] work_nxt;
  logic [3:0]  cnt;
  logic        digit_bad;

  // A nibble >= 8 after a right shift carried a "ten" down from the digit
  // above; removing 3 turns that 16-weighted bit into the 10-weighted one.
  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  // One iteration: shift the whole register, then correct each BCD nibble.
  function automatic logic [29:0] dabble_step(input logic [29:0] w);
    logic [29:0] s;
    s = w >> 1;
    s[29:26] = fix_nibble(s[29:26]);
    s[25:22] = fix_nibble(s[25:22]);
    s[21:18] = fix_nibble(s[21:18]);
    s[17:14] = fix_nibble(s[17:14]);
    return s;
  endfunction

  assign digit_bad = (thousands > 4'd9) | (hundreds > 4'd9) |
                     (tens > 4'd9) | (ones > 4'd9);

  assign work_nxt = dabble_step(work);

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (digit_bad) begin
              // Reject immediately; no conversion cycles are spent.
              done <= 1'b1;
              err  <= 1'b1;
              bin  <= '0;
              ovf  <= 1'b0;
            end else begin
              work  <= {thousands, hundreds, tens, ones, 14'd0};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            bin   <= work_nxt[13:0];
            ovf   <= (work_nxt[13:0] > MAX_BIN);
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_4digit.sv
// Directed testbench for bcd_to_bin_4digit.
module tb_bcd_to_bin_4digit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  thousands;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        busy;
  logic        done;
  logic [13:0] bin;
  logic        ovf;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_4digit #(.MAX_VAL(8191)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .bin       (bin),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on);
    thousands = th;
    hundreds  = hu;
    tens      = te;
    ones      = on;
  endtask

  // Single request; edge 0 is the accepting edge. Valid digits finish at
  // edge 14, invalid digits at edge 0.
  task automatic run_conv(input string tag,
                          input logic [3:0] th, input logic [3:0] hu,
                          input logic [3:0] te, input logic [3:0] on,
                          input int exp_bin, input int exp_ovf, input int exp_err);
    int done_edge;
    int busy_bad;
    logic exp_busy;
    done_edge = -1;
    busy_bad  = 0;
    exp_busy  = (exp_err == 0);
    @(negedge clk);
    set_digits(th, hu, te, on);
    start = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      if (done) begin
        done_edge = e;
        break;
      end
      if (busy !== exp_busy) busy_bad++;
    end
    check({tag, "_done_edge"}, done_edge, (exp_err != 0) ? 0 : 14);
    check({tag, "_bin"}, bin, exp_bin);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_busy_during"}, busy_bad, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_bin_hold"}, bin, exp_bin);
  endtask

  initial begin
    int n_done;
    int done_e0;
    int done_e1;
    int bin0;
    int bin1;

    rst   = 1'b1;
    start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bin", bin, 0);
    check("reset_ovf", ovf, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    run_conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
    run_conv("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 1234, 0, 0);
    run_conv("c8191", 4'd8, 4'd1, 4'd9, 4'd1, 8191, 0, 0);
    run_conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 9999, 1, 0);
    run_conv("c8192", 4'd8, 4'd1, 4'd9, 4'd2, 8192, 1, 0);
    run_conv("c00A5", 4'd0, 4'd0, 4'hA, 4'd5, 0, 0, 1);
    run_conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 42, 0, 0);
    run_conv("c0F00", 4'd0, 4'hF, 4'd0, 4'd0, 0, 0, 1);
    run_conv("c0607", 4'd0, 4'd6, 4'd0, 4'd7, 607, 0, 0);

    // Start during a conversion is ignored and digit changes have no effect.
    n_done  = 0;
    done_e0 = -1;
    bin0    = -1;
    @(negedge clk);
    set_digits(4'd5, 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      if (e == 4) begin
        set_digits(4'd0, 4'd0, 4'd0, 4'd1);
        start = 1'b1;
      end
      if (e == 5) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_e0 < 0) begin
          done_e0 = e;
          bin0    = int'(bin);
        end
      end
    end
    check("ign_done_edge", done_e0, 14);
    check("ign_bin", bin0, 5000);
    check("ign_done_count", n_done, 1);

    // Start held high across done: next request accepted at edge 15.
    n_done  = 0;
    done_e0 = -1;
    done_e1 = -1;
    bin0    = -1;
    bin1    = -1;
    @(negedge clk);
    set_digits(4'd1, 4'd1, 4'd1, 4'd1);
    start = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          done_e0 = e;
          bin0    = int'(bin);
        end else if (n_done == 2) begin
          done_e1 = e;
          bin1    = int'(bin);
        end
      end
      if (e == 14) set_digits(4'd2, 4'd2, 4'd2, 4'd2);
      if (e == 15) start = 1'b0;
    end
    check("b2b_done0_edge", done_e0, 14);
    check("b2b_bin0", bin0, 1111);
    check("b2b_done1_edge", done_e1, 29);
    check("b2b_bin1", bin1, 2222);
    check("b2b_done_count", n_done, 2);

    // Leave ovf and bin set so the abort must visibly clear them.
    run_conv("c9999b", 4'd9, 4'd9, 4'd9, 4'd9, 9999, 1, 0);

    // Asynchronous reset between E6 and E7 aborts the conversion.
    n_done = 0;
    @(negedge clk);
    set_digits(4'd7, 4'd7, 4'd7, 4'd7);
    start = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      if (done) n_done++;
    end
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin", bin, 0);
    check("abort_ovf", ovf, 0);
    check("abort_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle_busy", busy, 0);

    run_conv("c0009", 4'd0, 4'd0, 4'd0, 4'd9, 9, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
